// File: rtl/riscv_pkg.sv
// riscv_pkg: RV64I opcode constants, immediate formats and the ID/EX payload type.
package riscv_pkg;
   localparam int RV_XLEN = 64;
   localparam int RV_ILEN = 32;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_FENCE  = 7'h0F;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_IMM32  = 7'h1B;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP        = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_32     = 7'h3B;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

   typedef struct packed {
      logic [RV_XLEN-1:0] pc;
      logic [RV_XLEN-1:0] npc;
      logic [RV_XLEN-1:0] rs1val;
      logic [RV_XLEN-1:0] rs2val;
      logic [RV_XLEN-1:0] imm;
      logic [4:0]         rd;
      logic [6:0]         opcode;
      logic [2:0]         funct3;
      logic [6:0]         funct7;
      logic               memread;
      logic               memwrite;
      logic               regwrite;
      logic               illegal;
   } idex_t;

   function automatic logic is_legal(input logic [6:0] op);
      return op inside {OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_IMM32, OP_STORE, OP,
                        OP_LUI, OP_32, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
   endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for each RV64I instruction format.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int ILEN = RV_ILEN
) (
   input  logic [ILEN-1:0] instr,
   input  imm_type_t       imm_type,
   output logic [XLEN-1:0] imm
);
   always_comb begin
      imm = imm_type == IMM_I ? {{(XLEN-12){instr[31]}}, instr[31:20]} :
            imm_type == IMM_S ? {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]} :
            imm_type == IMM_B ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            imm_type == IMM_U ? {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0} :
            imm_type == IMM_J ? {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            '0;
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV64I IF/ID capture, combinational decode and ID/EX register,
// with load-use / backpressure stall and branch flush.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int ILEN = RV_ILEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            data_ack,
   input  logic [ILEN-1:0] instr_reg,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] IFID_npc,
   input  logic            EXIF_branch,
   input  logic            EX_ready,
   output logic            IDIF_stall,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            IDEX_valid,
   output logic [XLEN-1:0] IDEX_pc,
   output logic [XLEN-1:0] IDEX_npc,
   output logic [XLEN-1:0] IDEX_rs1val,
   output logic [XLEN-1:0] IDEX_rs2val,
   output logic [XLEN-1:0] IDEX_imm,
   output logic [4:0]      IDEX_rd,
   output logic [6:0]      IDEX_opcode,
   output logic [2:0]      IDEX_funct3,
   output logic [6:0]      IDEX_funct7,
   output logic            IDEX_memread,
   output logic            IDEX_memwrite,
   output logic            IDEX_regwrite,
   output logic            IDEX_illegal
);
   logic            ifid_valid;
   logic [ILEN-1:0] ifid_instr;
   logic [XLEN-1:0] ifid_pc, ifid_npc, imm;
   logic [6:0]      opcode;
   logic            legal, uses_rs1, uses_rs2, wb_op, loaduse;
   imm_type_t       imm_type;
   idex_t           idex, dec;

   assign opcode   = ifid_instr[6:0];
   assign rs1_addr = ifid_instr[19:15];
   assign rs2_addr = ifid_instr[24:20];

   always_comb begin
      legal    = is_legal(opcode);
      uses_rs1 = legal & !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
      uses_rs2 = legal & (opcode inside {OP_STORE, OP_BRANCH, OP, OP_32});
      wb_op    = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP, OP_IMM, OP_32, OP_IMM32};
      imm_type = opcode inside {OP_LOAD, OP_IMM, OP_IMM32, OP_JALR} ? IMM_I :
                 opcode == OP_STORE                               ? IMM_S :
                 opcode == OP_BRANCH                              ? IMM_B :
                 opcode inside {OP_LUI, OP_AUIPC}                 ? IMM_U :
                 opcode == OP_JAL                                 ? IMM_J : IMM_NONE;
   end

   imm_gen #(.XLEN(XLEN), .ILEN(ILEN)) u_imm_gen (.instr(ifid_instr), .imm_type(imm_type), .imm(imm));

   always_comb begin
      dec          = '0;
      dec.pc       = ifid_pc;
      dec.npc      = ifid_npc;
      dec.rs1val   = rs1_data;
      dec.rs2val   = rs2_data;
      dec.imm      = imm;
      dec.rd       = ifid_instr[11:7];
      dec.opcode   = opcode;
      dec.funct3   = ifid_instr[14:12];
      dec.funct7   = ifid_instr[31:25];
      dec.memread  = opcode == OP_LOAD;
      dec.memwrite = opcode == OP_STORE;
      dec.regwrite = wb_op & |ifid_instr[11:7];
      dec.illegal  = !legal;
   end

   assign loaduse = ifid_valid & IDEX_valid & idex.memread & |idex.rd &
                    ((uses_rs1 & rs1_addr == idex.rd) | (uses_rs2 & rs2_addr == idex.rd));
   assign IDIF_stall = !EXIF_branch & ifid_valid & (loaduse | !EX_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
         ifid_npc   <= '0;
      end else if (EXIF_branch) begin
         ifid_valid <= 1'b0;
      end else if (!IDIF_stall) begin
         ifid_valid <= data_ack;
         ifid_instr <= instr_reg;
         ifid_pc    <= pc;
         ifid_npc   <= IFID_npc;
      end
   end

   // A load-use bubble clears the payload so no stale write/store control leaks into execute.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         IDEX_valid <= 1'b0;
         idex       <= '0;
      end else if (EXIF_branch) begin
         IDEX_valid <= 1'b0;
      end else if (EX_ready) begin
         IDEX_valid <= ifid_valid & !loaduse;
         idex       <= loaduse ? '0 : dec;
      end
   end

   assign IDEX_pc       = idex.pc;
   assign IDEX_npc      = idex.npc;
   assign IDEX_rs1val   = idex.rs1val;
   assign IDEX_rs2val   = idex.rs2val;
   assign IDEX_imm      = idex.imm;
   assign IDEX_rd       = idex.rd;
   assign IDEX_opcode   = idex.opcode;
   assign IDEX_funct3   = idex.funct3;
   assign IDEX_funct7   = idex.funct7;
   assign IDEX_memread  = idex.memread;
   assign IDEX_memwrite = idex.memwrite;
   assign IDEX_regwrite = idex.regwrite;
   assign IDEX_illegal  = idex.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// slot-level reference model of the two pipeline registers.
module tb_decode_stage;
   logic        clk = 0, reset = 0, data_ack = 0, EXIF_branch = 0, EX_ready = 1;
   logic [31:0] instr_reg = 0;
   logic [63:0] pc = 0, IFID_npc = 0, rs1_data, rs2_data;
   logic        IDIF_stall, IDEX_valid, IDEX_memread, IDEX_memwrite, IDEX_regwrite, IDEX_illegal;
   logic [4:0]  rs1_addr, rs2_addr, IDEX_rd;
   logic [63:0] IDEX_pc, IDEX_npc, IDEX_rs1val, IDEX_rs2val, IDEX_imm;
   logic [6:0]  IDEX_opcode, IDEX_funct7;
   logic [2:0]  IDEX_funct3;
   logic [63:0] rf [32];

   typedef struct {bit v; logic [31:0] ins; logic [63:0] pc, npc;} slot_t;
   typedef struct packed {
      logic [63:0] pc, npc, r1, r2, imm;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        mr, mw, rw, ill;
   } fields_t;

   slot_t   m_if;
   bit      m_v;
   fields_t m_ex, dut_f;
   int      tests = 0, fails = 0;

   decode_stage dut (
      .clk(clk), .reset(reset), .data_ack(data_ack), .instr_reg(instr_reg), .pc(pc),
      .IFID_npc(IFID_npc), .EXIF_branch(EXIF_branch), .EX_ready(EX_ready), .IDIF_stall(IDIF_stall),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .IDEX_valid(IDEX_valid), .IDEX_pc(IDEX_pc), .IDEX_npc(IDEX_npc), .IDEX_rs1val(IDEX_rs1val),
      .IDEX_rs2val(IDEX_rs2val), .IDEX_imm(IDEX_imm), .IDEX_rd(IDEX_rd), .IDEX_opcode(IDEX_opcode),
      .IDEX_funct3(IDEX_funct3), .IDEX_funct7(IDEX_funct7), .IDEX_memread(IDEX_memread),
      .IDEX_memwrite(IDEX_memwrite), .IDEX_regwrite(IDEX_regwrite), .IDEX_illegal(IDEX_illegal));

   assign rs1_data = rf[rs1_addr];
   assign rs2_data = rf[rs2_addr];
   assign dut_f = {IDEX_pc, IDEX_npc, IDEX_rs1val, IDEX_rs2val, IDEX_imm, IDEX_rd, IDEX_opcode,
                   IDEX_funct3, IDEX_funct7, IDEX_memread, IDEX_memwrite, IDEX_regwrite, IDEX_illegal};

   always #5 clk = ~clk;

   function automatic bit legal(logic [6:0] op);
      return op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
   endfunction

   function automatic fields_t ref_dec(slot_t s);
      fields_t     f;
      logic [31:0] w = s.ins;
      logic [6:0]  op = w[6:0];
      f.pc = s.pc; f.npc = s.npc; f.r1 = rf[w[19:15]]; f.r2 = rf[w[24:20]];
      f.rd = w[11:7]; f.op = op; f.f3 = w[14:12]; f.f7 = w[31:25];
      case (op)
         7'h03, 7'h13, 7'h1B, 7'h67: f.imm = 64'($signed(w[31:20]));
         7'h23:                      f.imm = 64'($signed({w[31:25], w[11:7]}));
         7'h63:                      f.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         7'h37, 7'h17:               f.imm = 64'($signed({w[31:12], 12'h000}));
         7'h6F:                      f.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         default:                    f.imm = 64'd0;
      endcase
      f.mr  = op == 7'h03;
      f.mw  = op == 7'h23;
      f.ill = !legal(op);
      f.rw  = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h33, 7'h13, 7'h3B, 7'h1B}) && w[11:7] != 0;
      return f;
   endfunction

   function automatic bit m_loaduse();
      logic [6:0] op = m_if.ins[6:0];
      bit u1 = legal(op) && !(op inside {7'h37, 7'h17, 7'h6F});
      bit u2 = op inside {7'h23, 7'h63, 7'h33, 7'h3B};
      return m_if.v && m_v && m_ex.mr && m_ex.rd != 0 &&
             ((u1 && m_if.ins[19:15] == m_ex.rd) || (u2 && m_if.ins[24:20] == m_ex.rd));
   endfunction

   function automatic bit m_stall();
      return !EXIF_branch && m_if.v && (m_loaduse() || !EX_ready);
   endfunction

   task automatic model_reset();
      m_if = '{0, 0, 0, 0};
      m_v  = 0;
      m_ex = '0;
   endtask

   task automatic tick();
      bit      lu, st;
      fields_t d;
      @(posedge clk);
      lu = m_loaduse(); st = m_stall(); d = ref_dec(m_if);
      if (EXIF_branch) m_v = 0;
      else if (EX_ready) begin m_v = m_if.v && !lu; m_ex = lu ? '0 : d; end
      if (EXIF_branch) m_if.v = 0;
      else if (!st) m_if = '{data_ack, instr_reg, pc, IFID_npc};
      #1;
   endtask

   task automatic drive(bit ack, logic [31:0] ins, bit br, bit rdy);
      data_ack = ack; instr_reg = ins; EXIF_branch = br; EX_ready = rdy;
      pc = {$urandom, $urandom} & ~64'h3;
      IFID_npc = pc + 4;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (IDEX_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", IDEX_valid); end
      tests++; if (IDIF_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", IDIF_stall); end
      tests++; if (dut_f !== '0) begin fails++; $display("FAIL reset_fields got %h want 0", dut_f); end
      model_reset();
      reset = 1;
   endtask

   task automatic test_addi();
      drive(1, 32'h00500093, 0, 1); tick();
      drive(0, 32'h0, 0, 1); #1;
      tests++; if (rs1_addr !== 5'd0) begin fails++; $display("FAIL addi_rs1 got %0d want 0", rs1_addr); end
      tests++; if (IDEX_valid !== 1'b0) begin fails++; $display("FAIL addi_early got %b want 0", IDEX_valid); end
      tick(); #1;
      tests++; if ({IDEX_valid, IDEX_rd, IDEX_imm, IDEX_regwrite} !== {1'b1, 5'd1, 64'd5, 1'b1})
         begin fails++; $display("FAIL addi_out got v%b rd%0d imm%h rw%b want v1 rd1 imm5 rw1", IDEX_valid, IDEX_rd, IDEX_imm, IDEX_regwrite); end
      tests++; if (dut_f !== m_ex) begin fails++; $display("FAIL addi_fields got %h want %h", dut_f, m_ex); end
   endtask

   task automatic test_load_use();
      drive(1, 32'h00013283, 0, 1); tick();
      drive(1, 32'h00128333, 0, 1); #1;
      tests++; if (IDIF_stall !== 1'b0) begin fails++; $display("FAIL lu_pre got %b want 0", IDIF_stall); end
      tick(); drive(0, 32'h0, 0, 1); #1;
      tests++; if ({IDIF_stall, IDEX_memread, IDEX_rd} !== {1'b1, 1'b1, 5'd5})
         begin fails++; $display("FAIL lu_stall got st%b mr%b rd%0d want st1 mr1 rd5", IDIF_stall, IDEX_memread, IDEX_rd); end
      tick(); #1;
      tests++; if ({IDIF_stall, IDEX_valid, IDEX_regwrite, IDEX_memwrite} !== 4'b0000)
         begin fails++; $display("FAIL lu_bubble got st%b v%b rw%b mw%b want all 0", IDIF_stall, IDEX_valid, IDEX_regwrite, IDEX_memwrite); end
      tick(); #1;
      tests++; if ({IDEX_valid, IDEX_rd} !== {1'b1, 5'd6}) begin fails++; $display("FAIL lu_add got v%b rd%0d want v1 rd6", IDEX_valid, IDEX_rd); end
      tests++; if (dut_f !== m_ex) begin fails++; $display("FAIL lu_fields got %h want %h", dut_f, m_ex); end
   endtask

   task automatic test_branch();
      drive(1, 32'hFE000EE3, 0, 1); tick();
      drive(1, 32'h00100393, 0, 1); tick();
      tests++; if ({IDEX_valid, IDEX_imm, IDEX_regwrite} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0})
         begin fails++; $display("FAIL beq got v%b imm%h rw%b want v1 immfffffffffffffffc rw0", IDEX_valid, IDEX_imm, IDEX_regwrite); end
      drive(1, 32'h00100413, 0, 0); #1;
      tests++; if (IDIF_stall !== 1'b1) begin fails++; $display("FAIL br_stall got %b want 1", IDIF_stall); end
      EXIF_branch = 1; #1;
      tests++; if (IDIF_stall !== 1'b0) begin fails++; $display("FAIL br_beats_stall got %b want 0", IDIF_stall); end
      tick(); drive(0, 32'h0, 0, 1); #1;
      tests++; if ({IDEX_valid, IDIF_stall} !== 2'b00) begin fails++; $display("FAIL br_flush got v%b st%b want 00", IDEX_valid, IDIF_stall); end
      tick();
      tests++; if (IDEX_valid !== 1'b0) begin fails++; $display("FAIL br_dropped got %b want 0", IDEX_valid); end
   endtask

   task automatic test_backpressure();
      drive(1, 32'h00100393, 0, 1); tick();
      drive(1, 32'h00200413, 0, 1); tick();
      drive(1, 32'h00300493, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++; if ({IDIF_stall, IDEX_valid, IDEX_rd} !== {1'b1, 1'b1, 5'd7})
            begin fails++; $display("FAIL bp_hold%0d got st%b v%b rd%0d want st1 v1 rd7", k, IDIF_stall, IDEX_valid, IDEX_rd); end
         tests++; if (dut_f !== m_ex) begin fails++; $display("FAIL bp_fields%0d got %h want %h", k, dut_f, m_ex); end
         tick();
      end
      EX_ready = 1; tick();
      tests++; if ({IDEX_valid, IDEX_rd, IDEX_imm} !== {1'b1, 5'd8, 64'd2}) begin fails++; $display("FAIL bp_rel1 got v%b rd%0d want v1 rd8", IDEX_valid, IDEX_rd); end
      drive(0, 32'h0, 0, 1); tick();
      tests++; if ({IDEX_valid, IDEX_rd, IDEX_imm} !== {1'b1, 5'd9, 64'd3}) begin fails++; $display("FAIL bp_rel2 got v%b rd%0d want v1 rd9", IDEX_valid, IDEX_rd); end
      tick();
      tests++; if (IDEX_valid !== 1'b0) begin fails++; $display("FAIL bp_nodup got %b want 0", IDEX_valid); end
   endtask

   task automatic test_illegal_reset();
      drive(1, 32'h0, 0, 1); tick();
      drive(1, 32'h00100393, 0, 1); tick();
      tests++; if ({IDEX_valid, IDEX_illegal, IDEX_regwrite} !== 3'b110)
         begin fails++; $display("FAIL illegal got v%b ill%b rw%b want v1 ill1 rw0", IDEX_valid, IDEX_illegal, IDEX_regwrite); end
      EX_ready = 0; #1;
      tests++; if (IDIF_stall !== 1'b1) begin fails++; $display("FAIL ill_stall got %b want 1", IDIF_stall); end
      reset = 0; #1;
      tests++; if ({IDEX_valid, IDIF_stall} !== 2'b00) begin fails++; $display("FAIL async_reset got v%b st%b want 00", IDEX_valid, IDIF_stall); end
      model_reset();
      @(posedge clk); #1;
      drive(0, 32'h0, 0, 1);
      reset = 1;
   endtask

   task automatic test_random();
      logic [6:0]  ops [15] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h03, 7'h03, 7'h00, 7'h7F};
      logic [31:0] w;
      for (int n = 0; n < 400; n++) begin
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 14)];
         w[11:7] = 5'($urandom_range(0, 3));
         w[19:15] = 5'($urandom_range(0, 3));
         w[24:20] = 5'($urandom_range(0, 3));
         drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0);
         #1;
         tests++; if (IDIF_stall !== m_stall()) begin fails++; $display("FAIL rnd_stall@%0d got %b want %b", n, IDIF_stall, m_stall()); end
         tests++; if (IDEX_valid !== m_v) begin fails++; $display("FAIL rnd_valid@%0d got %b want %b", n, IDEX_valid, m_v); end
         if (m_v) begin
            tests++; if (dut_f !== m_ex) begin fails++; $display("FAIL rnd_fields@%0d got %h want %h", n, dut_f, m_ex); end
         end
         if (m_if.v) begin
            tests++; if ({rs1_addr, rs2_addr} !== {m_if.ins[19:15], m_if.ins[24:20]})
               begin fails++; $display("FAIL rnd_raddr@%0d got %0d/%0d want %0d/%0d", n, rs1_addr, rs2_addr, m_if.ins[19:15], m_if.ins[24:20]); end
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
      rf[0] = '0;
      test_reset();
      test_addi();
      test_load_use();
      test_branch();
      test_backpressure();
      test_illegal_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
